// File: rtl/pe_pkg.sv
// Shared constants and FSM state type for the processing-element operand feeder.
package pe_pkg;

    localparam int DATA_W     = 16;
    localparam int ACC_W      = 32;
    localparam int PE_LATENCY = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } feeder_state_t;

endpackage

// File: rtl/pe_sync_fifo.sv
// Synchronous FIFO with occupancy output; the caller must never push when full
// unless it pops on the same cycle.
module pe_sync_fifo #(
    parameter int WIDTH  = 33,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata,
    output logic [ADDR_W:0]   level
);

    logic [WIDTH-1:0]  mem_r [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_r;
    logic [ADDR_W-1:0] rd_ptr_r;
    logic [ADDR_W:0]   level_r;

    // Storage array; contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {ADDR_W{1'b0}};
            rd_ptr_r <= {ADDR_W{1'b0}};
            level_r  <= {(ADDR_W+1){1'b0}};
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + ADDR_W'(1);
            end
            case ({push, pop})
                2'b10:   level_r <= level_r + (ADDR_W+1)'(1);
                2'b01:   level_r <= level_r - (ADDR_W+1)'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    assign rdata = mem_r[rd_ptr_r];
    assign level = level_r;

endmodule

// File: rtl/pe_operand_feeder.sv
// Buffers operand pairs and issues one per cycle to the PE, inserting zero pairs
// while idle or draining. Optional issued-pair counter: define FEEDER_PAIR_CNT_EN.
module pe_operand_feeder #(
    parameter int DATA_W     = pe_pkg::DATA_W,
    parameter int DEPTH      = 8,
    parameter int ADDR_W     = $clog2(DEPTH),
    parameter int PE_LATENCY = pe_pkg::PE_LATENCY
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data_1,
    input  logic [DATA_W-1:0] s_data_2,
    input  logic              s_last,
    output logic [DATA_W-1:0] pe_data_1,
    output logic [DATA_W-1:0] pe_data_2,
    output logic              sum_valid,
    output logic              busy,
    output logic [ADDR_W:0]   level,
    output logic [31:0]       pair_count
);

    import pe_pkg::*;

    localparam int ENTRY_W = 2*DATA_W + 1;
    localparam int CNT_W   = (PE_LATENCY < 1) ? 1 : $clog2(PE_LATENCY + 1);

    feeder_state_t      state_r, state_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic [ADDR_W:0]    level_s;
    logic [ENTRY_W-1:0] head_s;
    logic [ENTRY_W-1:0] entry_s;
    logic               empty_s, full_s, ready_s, push_s, pop_s, sv_s;
    logic [DATA_W-1:0]  pe_data_1_r, pe_data_2_r;
    logic               sum_valid_r;

    assign entry_s = {s_last, s_data_1, s_data_2};
    assign empty_s = (level_s == {(ADDR_W+1){1'b0}});
    assign full_s  = (level_s == (ADDR_W+1)'(DEPTH));
    // A full FIFO still accepts when the head leaves on the same edge.
    assign ready_s = !full_s || pop_s;
    assign push_s  = s_valid && ready_s;

    pe_sync_fifo #(
        .WIDTH  (ENTRY_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (entry_s),
        .rdata (head_s),
        .level (level_s)
    );

    // Next-state, pop and checkpoint decision.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        pop_s   = 1'b0;
        sv_s    = 1'b0;
        case (state_r)
            IDLE, STREAM: begin
                if (!empty_s) begin
                    pop_s = 1'b1;
                    if (head_s[ENTRY_W-1]) begin
                        state_s = DRAIN;
                        cnt_s   = CNT_W'(PE_LATENCY);
                    end else begin
                        state_s = STREAM;
                    end
                end else begin
                    state_s = state_r;
                end
            end
            DRAIN: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    sv_s    = 1'b1;
                    state_s = empty_s ? IDLE : STREAM;
                end else begin
                    cnt_s = cnt_r - CNT_W'(1);
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // FSM state, drain counter and registered PE-facing outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            pe_data_1_r <= {DATA_W{1'b0}};
            pe_data_2_r <= {DATA_W{1'b0}};
            sum_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            pe_data_1_r <= pop_s ? head_s[2*DATA_W-1:DATA_W] : {DATA_W{1'b0}};
            pe_data_2_r <= pop_s ? head_s[DATA_W-1:0]        : {DATA_W{1'b0}};
            sum_valid_r <= sv_s;
        end
    end

`ifdef FEEDER_PAIR_CNT_EN
    logic [31:0] pair_count_r;

    // Issued-pair counter, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            pair_count_r <= 32'd0;
        end else if (pop_s) begin
            pair_count_r <= pair_count_r + 32'd1;
        end else begin
            pair_count_r <= pair_count_r;
        end
    end

    assign pair_count = pair_count_r;
`else
    assign pair_count = 32'd0;
`endif

    assign s_ready   = ready_s;
    assign pe_data_1 = pe_data_1_r;
    assign pe_data_2 = pe_data_2_r;
    assign sum_valid = sum_valid_r;
    assign busy      = !empty_s || (state_r != IDLE);
    assign level     = level_s;

endmodule

// File: tb/tb_pe_operand_feeder.sv
// Self-checking bench for pe_operand_feeder with a behavioural PE (accumulates
// data_in_1 + data_in_2, two-cycle latency) attached to its outputs.
module tb_pe_operand_feeder;

    localparam int DW    = 16;
    localparam int DEPTH = 8;
    localparam int AW    = $clog2(DEPTH);

    logic          clk, rst, s_valid, s_ready, s_last, sum_valid, busy;
    logic [DW-1:0] s_data_1, s_data_2, pe_data_1, pe_data_2;
    logic [AW:0]   level;
    logic [31:0]   pair_count;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    pe_operand_feeder #(.DATA_W(DW), .DEPTH(DEPTH), .PE_LATENCY(2)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
        .s_data_1(s_data_1), .s_data_2(s_data_2), .s_last(s_last),
        .pe_data_1(pe_data_1), .pe_data_2(pe_data_2), .sum_valid(sum_valid),
        .busy(busy), .level(level), .pair_count(pair_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference PE: input stage then accumulator.
    int stage_m, acc_m;
    always @(posedge clk) begin
        if (rst) begin
            stage_m <= 0;
            acc_m   <= 0;
        end else begin
            stage_m <= int'($signed(pe_data_1)) + int'($signed(pe_data_2));
            acc_m   <= acc_m + stage_m;
        end
    end

    typedef struct { int d1; int d2; int c; } pair_t;
    pair_t issued_q[$];
    int    sv_q[$];
    int    max_level;
    bit    saw_full_stall;

    // Records issued (non-zero) pairs, checkpoints and FIFO fullness.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!rst) begin
            if (pe_data_1 != '0 || pe_data_2 != '0)
                issued_q.push_back('{d1: int'($signed(pe_data_1)), d2: int'($signed(pe_data_2)), c: cyc});
            if (sum_valid) sv_q.push_back(acc_m);
            if (int'(level) > max_level) max_level = int'(level);
            if (int'(level) == DEPTH && !s_ready) saw_full_stall = 1'b1;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int exp_pc(input int n);
`ifdef FEEDER_PAIR_CNT_EN
        return n;
`else
        return 0 * n;
`endif
    endfunction

    task automatic restart();
        rst = 1'b1; s_valid = 1'b0; s_last = 1'b0;
        s_data_1 = '0; s_data_2 = '0;
        @(negedge clk);
        issued_q.delete(); sv_q.delete();
        max_level = 0; saw_full_stall = 1'b0;
        rst = 1'b0;
    endtask

    task automatic push(input int d1, input int d2, input bit last);
        int n = 0;
        s_valid = 1'b1; s_data_1 = DW'(d1); s_data_2 = DW'(d2); s_last = last;
        while (!s_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) check("push_timeout", n, 0);
        @(negedge clk);
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 300);
        if (busy) check("idle_timeout", n, 0);
        repeat (2) @(negedge clk);
    endtask

    typedef struct {
        bit v; int d1; int d2; bit last;
        int e1; int e2; int elev; bit erdy; bit esv; int eacc;
    } vec_t;
    vec_t tbl[9];

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1);
    end

    initial begin
        // Single vector (3,4),(-5,2),(7,-1)+last; row 3 has s_last with s_valid low.
        tbl[0] = '{1'b1,  3,  4, 1'b0,  0,  0, 0, 1'b1, 1'b0,  0};
        tbl[1] = '{1'b1, -5,  2, 1'b0,  0,  0, 1, 1'b1, 1'b0,  0};
        tbl[2] = '{1'b1,  7, -1, 1'b1,  3,  4, 1, 1'b1, 1'b0,  0};
        tbl[3] = '{1'b0, 99, 99, 1'b1, -5,  2, 1, 1'b1, 1'b0,  0};
        tbl[4] = '{1'b0,  0,  0, 1'b0,  7, -1, 0, 1'b1, 1'b0,  0};
        tbl[5] = '{1'b0,  0,  0, 1'b0,  0,  0, 0, 1'b1, 1'b0,  0};
        tbl[6] = '{1'b0,  0,  0, 1'b0,  0,  0, 0, 1'b1, 1'b0,  0};
        tbl[7] = '{1'b0,  0,  0, 1'b0,  0,  0, 0, 1'b1, 1'b1, 10};
        tbl[8] = '{1'b0,  0,  0, 1'b0,  0,  0, 0, 1'b1, 1'b0,  0};

        restart();
        check("rst_pe1", int'(pe_data_1), 0);
        check("rst_pe2", int'(pe_data_2), 0);
        check("rst_level", int'(level), 0);
        check("rst_sv", int'(sum_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_ready", int'(s_ready), 1);
        check("rst_pc", int'(pair_count), 0);

        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            check($sformatf("v%0d_pe1", i), int'($signed(pe_data_1)), tbl[i].e1);
            check($sformatf("v%0d_pe2", i), int'($signed(pe_data_2)), tbl[i].e2);
            check($sformatf("v%0d_level", i), int'(level), tbl[i].elev);
            check($sformatf("v%0d_ready", i), int'(s_ready), int'(tbl[i].erdy));
            check($sformatf("v%0d_sv", i), int'(sum_valid), int'(tbl[i].esv));
            if (tbl[i].esv) check($sformatf("v%0d_acc", i), acc_m, tbl[i].eacc);
            s_valid = tbl[i].v; s_data_1 = DW'(tbl[i].d1);
            s_data_2 = DW'(tbl[i].d2); s_last = tbl[i].last;
        end
        s_valid = 1'b0; s_last = 1'b0;
        check("single_pc", int'(pair_count), exp_pc(3));

        // Two single-pair vectors back-to-back.
        restart();
        push(1, 1, 1'b1);
        push(100, -50, 1'b1);
        wait_idle();
        check("b2b_nsv", sv_q.size(), 2);
        if (sv_q.size() == 2) begin
            check("b2b_ck0", sv_q[0], 2);
            check("b2b_ck1", sv_q[1], 52);
        end
        check("b2b_nissue", issued_q.size(), 2);
        if (issued_q.size() == 2) check("b2b_gap", issued_q[1].c - issued_q[0].c, 4);
        check("b2b_pc", int'(pair_count), exp_pc(2));

        // Fill: every pair is a vector end, so drains stall pops and the FIFO fills.
        restart();
        for (int k = 0; k < 12; k++) push(k + 1, 2*(k + 1), 1'b1);
        wait_idle();
        check("fill_maxlvl", max_level, DEPTH);
        check("fill_stall", int'(saw_full_stall), 1);
        check("fill_nissue", issued_q.size(), 12);
        check("fill_nsv", sv_q.size(), 12);
        begin
            int run = 0;
            for (int k = 0; k < 12; k++) begin
                run += 3*(k + 1);
                if (k < issued_q.size()) begin
                    check($sformatf("fill_d1_%0d", k), issued_q[k].d1, k + 1);
                    check($sformatf("fill_d2_%0d", k), issued_q[k].d2, 2*(k + 1));
                end
                if (k < sv_q.size()) check($sformatf("fill_ck_%0d", k), sv_q[k], run);
            end
        end
        check("fill_pc", int'(pair_count), exp_pc(12));

        // Extremes with pointer wrap: 20 x (-32768, 32767), last on the 20th.
        restart();
        for (int k = 1; k <= 20; k++) push(-32768, 32767, k == 20);
        wait_idle();
        check("wrap_nsv", sv_q.size(), 1);
        if (sv_q.size() == 1) check("wrap_ck", sv_q[0], -20);
        check("wrap_nissue", issued_q.size(), 20);
        begin
            int bad = 0;
            foreach (issued_q[k]) if (issued_q[k].d1 != -32768 || issued_q[k].d2 != 32767) bad++;
            check("wrap_data", bad, 0);
        end
        check("wrap_pc", int'(pair_count), exp_pc(20));

        // Reset during DRAIN suppresses the pending checkpoint.
        restart();
        push(9, 9, 1'b1);
        begin
            int n = 0;
            while (pe_data_1 != 16'd9 && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        check("mid_issue", int'(pe_data_1), 9);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("mid_nsv", sv_q.size(), 0);
        check("mid_busy", int'(busy), 0);
        check("mid_level", int'(level), 0);
        check("mid_pe1", int'(pe_data_1), 0);
        check("mid_pc", int'(pair_count), 0);

        // Reset with buffered pairs and a push on the reset edge.
        restart();
        push(11, 12, 1'b0);
        push(13, 14, 1'b0);
        s_valid = 1'b1; s_data_1 = 16'd15; s_data_2 = 16'd16; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; s_valid = 1'b0;
        check("rst2_pe1", int'(pe_data_1), 0);
        check("rst2_pe2", int'(pe_data_2), 0);
        check("rst2_level", int'(level), 0);
        check("rst2_sv", int'(sum_valid), 0);
        check("rst2_busy", int'(busy), 0);
        check("rst2_ready", int'(s_ready), 1);
        check("rst2_pc", int'(pair_count), 0);
        repeat (6) @(negedge clk);
        check("rst2_nsv", sv_q.size(), 0);
        check("rst2_pe_after", int'(pe_data_1), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
